game_objects_axil_slave: RTL and testbench
==========================================

GAME_OBJECTS_AXIL_SLAVE -- requirements
Module: game_objects_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, register and data bus width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte-address width covering four word registers.
REQ-003 SHALL have ports: ACLK  in  1  sole clock. Reset is asynchronous and active-low.
REQ-004 ARESETN  in  1  asynchronous active-low reset.
REQ-005 AWADDR in 4 write address; AWPROT in 3 ignored; AWVALID in 1; AWREADY out 1.
REQ-006 WDATA in 32; WSTRB in 4 byte enables; WVALID in 1; WREADY out 1.
REQ-007 BRESP out 2; BVALID out 1; BREADY in 1.
REQ-008 ARADDR in 4; ARPROT in 3 ignored; ARVALID in 1; ARREADY out 1.
REQ-009 RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1.
REQ-010 frame_sync  in  1  one-cycle pulse at vertical blank, ACLK domain.
REQ-011 obj0..obj3  out  32 each  frame-stable shadow copies of reg0..reg3 for the renderer.

Function
REQ-012 SHALL decode four registers at byte offsets 0x0, 0x4, 0x8 and 0xC using ADDR[3:2]; ADDR[1:0] is ignored.
REQ-013 Write channel SHALL accept AW and W independently and in either order, each latched in its own holding register.
REQ-014 AWREADY SHALL be high while no address is held and BVALID is low; WREADY follows the same rule for data.
REQ-015 When both address and data are held, the block SHALL update the addressed register in that cycle, byte-merged per WSTRB, and SHALL assert BVALID with BRESP=00 on the next edge.
REQ-016 AW and W arriving in the same cycle SHALL both be accepted; the register write occurs one cycle later.
REQ-017 BVALID SHALL stay high until BREADY is sampled high; no new AW or W is accepted while BVALID is high.
REQ-018 WSTRB=0000 SHALL complete with an OKAY response and leave the register unchanged.
REQ-019 ARREADY SHALL be high whenever RVALID is low.
REQ-020 On an AR handshake, RDATA SHALL register the addressed value and RVALID SHALL rise on the next edge, giving 1-cycle read latency. RRESP SHALL be 00.
REQ-021 RDATA and RVALID SHALL hold until RREADY is sampled high; at most one read is outstanding.
REQ-022 A read and a write to the same register in the same cycle SHALL return the pre-write value.
REQ-023 Read and write channels SHALL operate concurrently without mutual stalling.
REQ-024 On frame_sync=1, obj0..obj3 SHALL load reg0..reg3 at that edge; otherwise they hold.
REQ-025 A register write and frame_sync in the same cycle: obj SHALL capture the old value, and the new value appears at the next frame_sync.
REQ-026 Write handling SHALL be a 2-state FSM: W_IDLE (collecting AW/W) and W_RESP (BVALID high). Read handling SHALL be a 2-state FSM: R_IDLE and R_DATA.

Reset
REQ-027 ARESETN low SHALL asynchronously clear reg0..reg3, obj0..obj3, both holding registers, BVALID, RVALID, RDATA and BRESP/RRESP to 0.
REQ-028 While in reset, AWREADY, WREADY and ARREADY SHALL be 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction: no BVALID/RVALID after release and no partial register update.
REQ-030 Ready outputs SHALL assert no earlier than the first rising edge after ARESETN deasserts.

Structure
REQ-031 A shared package game_objects_pkg SHALL hold the register offsets, the AXI response codes (OKAY=2'b00) and the FSM state enums.
REQ-032 A single sub-module axil_byte_merge (old word, new word, strobe -> merged word) is permitted; all other logic SHALL be flat.

Verification
REQ-033 Sequential writes 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC with WSTRB=F, then reads -> RDATA 1,2,3,4 with RRESP=00 and BRESP=00.
REQ-034 W presented 3 cycles before AW (0xDEADBEEF to 0x8) -> exactly one write; reading 0x8 returns 0xDEADBEEF.
REQ-035 Write 0xFFFFFFFF then 0x12345678 with WSTRB=0101 to 0x4 -> read 0xFF34FF78.
REQ-036 BREADY and RREADY held low for 5 cycles -> BVALID, RVALID and RDATA stable throughout, and AWREADY low.
REQ-037 Write 0xA5 to 0x0 in the same cycle as frame_sync -> obj0 keeps its old value, then becomes 0xA5 after the next frame_sync.
REQ-038 ARESETN pulsed low between an AW handshake and its W -> no BVALID after release, and reg0..reg3 read back 0.

Source files
------------

// File: rtl/game_objects_pkg.sv
// Shared definitions for the game-object register block: register map,
// AXI response codes and the write/read channel state encodings.
package game_objects_pkg;

  localparam int unsigned NUM_REGS = 4;

  // Byte offsets of the four object registers; ADDR[3:2] selects the word.
  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axil_byte_merge.sv
// Byte-lane merge: each strobe bit selects the new byte, otherwise the old
// byte is kept. An all-zero strobe returns the old word unchanged.
module axil_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged_word
);

  // Per-lane select between old and new byte.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (strb[i]) merged_word[i*8 +: 8] = new_word[i*8 +: 8];
    end
  end

endmodule

// File: rtl/game_objects_axil_slave.sv
// AXI4-Lite slave holding four object registers, with frame-synchronous
// shadow copies presented to the renderer.
//
// state  | meaning
// W_IDLE | collecting AW and W into their holding registers
// W_RESP | register written, BVALID high until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RDATA/RVALID held until RREADY
module game_objects_axil_slave
  import game_objects_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  input  logic                            frame_sync,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   obj0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   obj1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   obj2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   obj3
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic              ready_en;
  logic              aw_held;
  logic [1:0]        aw_idx_q;
  logic              w_held;
  logic [DW-1:0]     w_data_q;
  logic [DW/8-1:0]   w_strb_q;
  logic [DW-1:0]     regs  [NUM_REGS];
  logic [DW-1:0]     obj_q [NUM_REGS];
  logic [DW-1:0]     rdata_q;
  logic [DW-1:0]     merged_word;
  logic              aw_hs, w_hs, ar_hs, do_write;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  assign AWREADY  = ready_en & ~aw_held & (w_state == W_IDLE);
  assign WREADY   = ready_en & ~w_held  & (w_state == W_IDLE);
  assign ARREADY  = ready_en & (r_state == R_IDLE);
  assign BVALID   = (w_state == W_RESP);
  assign RVALID   = (r_state == R_DATA);
  assign BRESP    = RESP_OKAY;
  assign RRESP    = RESP_OKAY;
  assign RDATA    = rdata_q;

  assign aw_hs    = AWVALID & AWREADY;
  assign w_hs     = WVALID & WREADY;
  assign ar_hs    = ARVALID & ARREADY;
  assign do_write = (w_state == W_IDLE) & aw_held & w_held;

  assign obj0 = obj_q[0];
  assign obj1 = obj_q[1];
  assign obj2 = obj_q[2];
  assign obj3 = obj_q[3];

  axil_byte_merge #(.DATA_WIDTH(DW)) u_merge (
    .old_word   (regs[aw_idx_q]),
    .new_word   (w_data_q),
    .strb       (w_strb_q),
    .merged_word(merged_word)
  );

  // Ready outputs stay low until the first clock edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Channel state registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Write channel next state: respond once both halves are held.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (do_write) w_state_nxt = W_RESP;
      W_RESP:  if (BREADY)   w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read channel next state: one outstanding read at a time.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)  r_state_nxt = R_DATA;
      R_DATA:  if (RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // AW and W holding registers, filled independently and drained together.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= AWADDR[3:2];
      end else if (do_write) begin
        aw_held  <= 1'b0;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end else if (do_write) begin
        w_held   <= 1'b0;
      end
    end
  end

  // Register file update and frame-synchronous shadow capture; shadows
  // see the pre-write value when both happen on the same edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i]  <= '0;
        obj_q[i] <= '0;
      end
    end else begin
      if (do_write) regs[aw_idx_q] <= merged_word;
      if (frame_sync) begin
        for (int i = 0; i < NUM_REGS; i++) obj_q[i] <= regs[i];
      end
    end
  end

  // Read data capture on the address handshake; held while RVALID is high.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)   rdata_q <= '0;
    else if (ar_hs) rdata_q <= regs[ARADDR[3:2]];
  end

endmodule

// File: tb/tb_game_objects_axil_slave.sv
// Directed bench for game_objects_axil_slave with a queue-based scoreboard:
// stimulus pushes expected B/R responses, a monitor pops on each handshake.
module tb_game_objects_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [3:0]  ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic        frame_sync = 1'b0;
  logic [31:0] obj0, obj1, obj2, obj3;

  int errors = 0;
  int checks = 0;
  logic [1:0]  b_q [$];
  logic [31:0] r_q [$];

  game_objects_axil_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .frame_sync(frame_sync),
    .obj0(obj0), .obj1(obj1), .obj2(obj2), .obj3(obj3)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic wait_b_empty();
    for (int n = 0; n < 30 && b_q.size() > 0; n++) begin
      @(posedge ACLK); #1;
    end
    if (b_q.size() > 0) begin
      fail_now("b_wait");
      b_q.delete();
    end
  endtask

  task automatic wait_r_empty();
    for (int n = 0; n < 30 && r_q.size() > 0; n++) begin
      @(posedge ACLK); #1;
    end
    if (r_q.size() > 0) begin
      fail_now("r_wait");
      r_q.delete();
    end
  endtask

  // Presents W immediately and AW after w_lead cycles; returns once both
  // handshakes are done (called and returns just after a rising edge).
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input bit wait_b);
    bit aw_pend, w_pend, aw_hs, w_hs;
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    b_q.push_back(2'b00);
    AWADDR = a;
    WDATA  = d;
    WSTRB  = s;
    WVALID = 1'b1;
    for (int n = 0; n < 30 && (aw_pend || w_pend); n++) begin
      if (n >= w_lead && aw_pend) AWVALID = 1'b1;
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin WVALID  = 1'b0; w_pend  = 1'b0; end
    end
    if (aw_pend || w_pend) begin
      fail_now("write_accept");
      AWVALID = 1'b0;
      WVALID  = 1'b0;
    end
    if (wait_b) wait_b_empty();
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input bit wait_r);
    bit pend, hs;
    pend = 1'b1;
    r_q.push_back(exp);
    ARADDR  = a;
    ARVALID = 1'b1;
    for (int n = 0; n < 30 && pend; n++) begin
      @(negedge ACLK);
      hs = ARVALID && ARREADY;
      @(posedge ACLK); #1;
      if (hs) begin ARVALID = 1'b0; pend = 1'b0; end
    end
    if (pend) begin
      fail_now("read_accept");
      ARVALID = 1'b0;
    end
    if (wait_r) wait_r_empty();
  endtask

  task automatic pulse_frame_sync();
    frame_sync = 1'b1;
    @(posedge ACLK); #1;
    frame_sync = 1'b0;
  endtask

  initial begin
    fork
      // Monitor: compare each B/R handshake against the scoreboard queues.
      begin
        forever begin
          @(negedge ACLK);
          if (BVALID && BREADY) begin
            if (b_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_b: got BVALID expected none");
            end else begin
              check("bresp", {30'd0, BRESP}, {30'd0, b_q.pop_front()});
            end
          end
          if (RVALID && RREADY) begin
            if (r_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_r: got RVALID expected none");
            end else begin
              check("rdata", RDATA, r_q.pop_front());
              check("rresp", {30'd0, RRESP}, 32'd0);
            end
          end
        end
      end
      // Watchdog.
      begin
        #400000;
        fail_now("watchdog");
      end
      // Stimulus.
      begin
        #12;
        check("rst_awready", {31'd0, AWREADY}, 32'd0);
        check("rst_wready",  {31'd0, WREADY},  32'd0);
        check("rst_arready", {31'd0, ARREADY}, 32'd0);
        check("rst_bvalid",  {31'd0, BVALID},  32'd0);
        check("rst_rvalid",  {31'd0, RVALID},  32'd0);
        check("rst_rdata",   RDATA, 32'd0);
        check("rst_obj0",    obj0,  32'd0);
        check("rst_obj3",    obj3,  32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        check("rel_awready_early", {31'd0, AWREADY}, 32'd0);
        @(posedge ACLK); #1;
        check("rel_awready", {31'd0, AWREADY}, 32'd1);
        check("rel_arready", {31'd0, ARREADY}, 32'd1);

        // Sequential writes then reads.
        axi_write(4'h0, 32'h1, 4'hF, 0, 1'b1);
        axi_write(4'h4, 32'h2, 4'hF, 0, 1'b1);
        axi_write(4'h8, 32'h3, 4'hF, 0, 1'b1);
        axi_write(4'hC, 32'h4, 4'hF, 0, 1'b1);
        axi_read(4'h0, 32'h1, 1'b1);
        axi_read(4'h4, 32'h2, 1'b1);
        axi_read(4'h8, 32'h3, 1'b1);
        axi_read(4'hC, 32'h4, 1'b1);

        // W three cycles ahead of AW; sub-word address bits ignored.
        axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 1'b1);
        axi_read(4'hB, 32'hDEADBEEF, 1'b1);

        // Partial strobe merge, and an empty strobe leaves the word alone.
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 1'b1);
        axi_write(4'h4, 32'h12345678, 4'b0101, 0, 1'b1);
        axi_write(4'h4, 32'h00000000, 4'b0000, 0, 1'b1);
        axi_read(4'h4, 32'hFF34FF78, 1'b1);

        // Back-pressure on B and R.
        BREADY = 1'b0;
        RREADY = 1'b0;
        axi_write(4'hC, 32'h00000055, 4'hF, 0, 1'b0);
        axi_read(4'h0, 32'h1, 1'b0);
        @(posedge ACLK); #1;
        for (int n = 0; n < 5; n++) begin
          @(negedge ACLK);
          check("hold_bvalid",  {31'd0, BVALID},  32'd1);
          check("hold_rvalid",  {31'd0, RVALID},  32'd1);
          check("hold_rdata",   RDATA, 32'h1);
          check("hold_awready", {31'd0, AWREADY}, 32'd0);
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1;
        RREADY = 1'b1;
        wait_b_empty();
        wait_r_empty();
        axi_read(4'hC, 32'h55, 1'b1);

        // Frame sync shadows.
        pulse_frame_sync();
        check("fs_obj0", obj0, 32'h1);
        check("fs_obj1", obj1, 32'hFF34FF78);
        check("fs_obj2", obj2, 32'hDEADBEEF);
        check("fs_obj3", obj3, 32'h55);
        axi_write(4'h0, 32'hA5, 4'hF, 0, 1'b0);
        pulse_frame_sync();
        check("fs_same_cycle_obj0", obj0, 32'h1);
        wait_b_empty();
        check("fs_hold_obj0", obj0, 32'h1);
        pulse_frame_sync();
        check("fs_next_obj0", obj0, 32'hA5);
        axi_read(4'h0, 32'hA5, 1'b1);

        // Reset between an AW handshake and its W.
        AWADDR  = 4'h0;
        AWVALID = 1'b1;
        @(negedge ACLK);
        check("abort_aw_hs", {31'd0, AWREADY}, 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        #2;
        ARESETN = 1'b0;
        #1;
        check("inrst_awready", {31'd0, AWREADY}, 32'd0);
        check("inrst_wready",  {31'd0, WREADY},  32'd0);
        check("inrst_arready", {31'd0, ARREADY}, 32'd0);
        check("inrst_obj0",    obj0, 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        WDATA  = 32'h11111111;
        WSTRB  = 4'hF;
        WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        for (int n = 0; n < 4; n++) begin
          @(negedge ACLK);
          check("abort_bvalid", {31'd0, BVALID}, 32'd0);
        end
        @(posedge ACLK); #1;
        axi_read(4'h0, 32'h0, 1'b1);
        axi_read(4'h4, 32'h0, 1'b1);
        axi_read(4'h8, 32'h0, 1'b1);
        axi_read(4'hC, 32'h0, 1'b1);
        repeat (3) @(posedge ACLK);
        #1;
        check("b_queue_left", b_q.size(), 32'd0);
        check("r_queue_left", r_q.size(), 32'd0);
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
